// File: rtl/chip_test_scheduler.sv
// Sequencer that shares one DUT socket between NUM_CHIPS tester modules: run, route pins, time out,
// hold the result for display, release. Define CHIP_TEST_RETRY_EN to retry a failing part once.
`timescale 1ns/1ps
module chip_test_scheduler #(
  parameter int unsigned NUM_CHIPS   = 8,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned PIN_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [SEL_W-1:0]           Chip_Sel,
  input  logic                       Ack,
  input  logic [NUM_CHIPS-1:0]       Tester_Done,
  input  logic [NUM_CHIPS-1:0]       Tester_Rslt,
  input  logic [NUM_CHIPS*PIN_W-1:0] Tester_Pin_Out,
  input  logic [NUM_CHIPS*PIN_W-1:0] Tester_Pin_Oe,
  output logic [NUM_CHIPS-1:0]       Tester_Run,
  output logic [NUM_CHIPS-1:0]       Tester_Disp,
  output logic [PIN_W-1:0]           Socket_Pin_Out,
  output logic [PIN_W-1:0]           Socket_Pin_Oe,
  output logic [SEL_W-1:0]           Active_Sel,
  output logic                       Busy,
  output logic                       Result_Valid,
  output logic                       Pass,
  output logic                       Timeout,
  output logic                       Sel_Err,
  output logic                       Retried
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StWait,
    StReport,
    StRelease
`ifdef CHIP_TEST_RETRY_EN
    , StRetryRel
`endif
  } state_e;

  state_e              state_q, state_d;
  logic                start_q;
  logic [SEL_W-1:0]    active_sel_q, active_sel_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic                sel_err_q, sel_err_d;
  logic                retried_q, retried_d;

  logic                start_edge;
  logic                sel_valid;
  logic                done_sel;
  logic                rslt_sel;
  logic [PIN_W-1:0]    pin_out_sel;
  logic [PIN_W-1:0]    pin_oe_sel;
  logic [NUM_CHIPS-1:0] sel_onehot;

  assign start_edge = Start & ~start_q;
  assign sel_valid  = 32'(Chip_Sel) < NUM_CHIPS;

  // Pick out the latched tester's handshake and pin bundle.
  always_comb begin
    done_sel    = 1'b0;
    rslt_sel    = 1'b0;
    pin_out_sel = '0;
    pin_oe_sel  = '0;
    sel_onehot  = '0;
    for (int k = 0; k < int'(NUM_CHIPS); k++) begin
      if (active_sel_q == SEL_W'(k)) begin
        done_sel      = Tester_Done[k];
        rslt_sel      = Tester_Rslt[k];
        pin_out_sel   = Tester_Pin_Out[k*PIN_W +: PIN_W];
        pin_oe_sel    = Tester_Pin_Oe[k*PIN_W +: PIN_W];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    active_sel_d   = active_sel_q;
    timer_d        = timer_q;
    pass_d         = pass_q;
    timeout_d      = timeout_q;
    sel_err_d      = sel_err_q;
    retried_d      = retried_q;
    Tester_Run     = '0;
    Tester_Disp    = '0;
    Socket_Pin_Out = '0;
    Socket_Pin_Oe  = '0;
    Result_Valid   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          if (sel_valid) begin
            active_sel_d = Chip_Sel;
            pass_d       = 1'b0;
            timeout_d    = 1'b0;
            sel_err_d    = 1'b0;
            retried_d    = 1'b0;
            state_d      = StRun;
          end else begin
            sel_err_d = 1'b1;
            pass_d    = 1'b0;
            state_d   = StReport;
          end
        end
      end
      StRun: begin
        Tester_Run = sel_onehot;
        timer_d    = '0;
        state_d    = StWait;
      end
      StWait: begin
        Socket_Pin_Out = pin_out_sel;
        Socket_Pin_Oe  = pin_oe_sel;
        timer_d        = timer_q + TimerW'(1);
        // Done outranks the terminal count on the same cycle.
        if (done_sel) begin
          pass_d  = rslt_sel;
          state_d = StReport;
`ifdef CHIP_TEST_RETRY_EN
          if (!rslt_sel && !retried_q) begin
            retried_d = 1'b1;
            state_d   = StRetryRel;
          end
`endif
        end else if (timer_q == TimerLast) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = StReport;
        end
      end
      StReport: begin
        Result_Valid = 1'b1;
        if (Ack) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!sel_err_q) begin
          Tester_Disp = sel_onehot;
        end
        if (sel_err_q || !done_sel) begin
          state_d = StIdle;
        end
      end
`ifdef CHIP_TEST_RETRY_EN
      StRetryRel: begin
        Tester_Disp = sel_onehot;
        if (!done_sel) begin
          state_d = StRun;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      active_sel_q <= '0;
      timer_q      <= '0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      sel_err_q    <= 1'b0;
      retried_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= Start;
      active_sel_q <= active_sel_d;
      timer_q      <= timer_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      sel_err_q    <= sel_err_d;
      retried_q    <= retried_d;
    end
  end

  assign Active_Sel = active_sel_q;
  assign Busy       = state_q != StIdle;
  assign Pass       = pass_q;
  assign Timeout    = timeout_q;
  assign Sel_Err    = sel_err_q;
  assign Retried    = retried_q;

endmodule
